// File: rtl/drop_controller.sv
// drop_controller: turns debounced button presses into cursor moves, legal drops and turn alternation
module drop_controller #(
  parameter int ROWS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_drop,
  input  logic       game_over,
  input  logic [2:0] height_0,
  input  logic [2:0] height_1,
  input  logic [2:0] height_2,
  input  logic [2:0] height_3,
  output logic [1:0] cursor,
  output logic       player,
  output logic [1:0] counter,
  output logic       add,
  output logic       place_valid,
  output logic [2:0] place_row,
  output logic [1:0] place_col,
  output logic       place_player,
  output logic       rejected
);
  typedef enum logic [1:0] {IDLE, DROP, SETTLE} state_t;
  state_t     state_q, state_d;
  logic [2:0] hist_q, ev, h_sel;
  logic [1:0] cursor_q, cursor_d, counter_q, counter_d, col_q, col_d;
  logic [2:0] row_q, row_d;
  logic       player_q, player_d, add_q, add_d, pv_q, pv_d, rej_q, rej_d, pp_q, pp_d, full;
  // bits are {drop, right, left}; history resets high so a held button yields no event
  assign ev = {btn_drop, btn_right, btn_left} & ~hist_q;
  always_comb
    h_sel = cursor_q == 2'd0 ? height_0 :
            cursor_q == 2'd1 ? height_1 :
            cursor_q == 2'd2 ? height_2 : height_3;
  assign full = 32'(h_sel) >= ROWS;
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    player_d  = player_q;
    counter_d = counter_q;
    add_d     = 1'b0;
    pv_d      = 1'b0;
    rej_d     = 1'b0;
    row_d     = row_q;
    col_d     = col_q;
    pp_d      = pp_q;
    case (state_q)
      IDLE:
        if (ev[2]) begin
          if (game_over || full) rej_d = 1'b1;
          else begin
            state_d   = DROP;
            add_d     = 1'b1;
            counter_d = cursor_q;
            pv_d      = 1'b1;
            row_d     = h_sel;
            col_d     = cursor_q;
            pp_d      = player_q;
          end
        end else if (ev[1] ^ ev[0]) cursor_d = ev[0] ? cursor_q - 2'd1 : cursor_q + 2'd1;
      DROP: begin
        state_d  = SETTLE;
        player_d = ~player_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      hist_q    <= 3'b111;
      cursor_q  <= '0;
      player_q  <= 1'b0;
      counter_q <= '0;
      add_q     <= 1'b0;
      pv_q      <= 1'b0;
      rej_q     <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      pp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= {btn_drop, btn_right, btn_left};
      cursor_q  <= cursor_d;
      player_q  <= player_d;
      counter_q <= counter_d;
      add_q     <= add_d;
      pv_q      <= pv_d;
      rej_q     <= rej_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pp_q      <= pp_d;
    end
  assign cursor       = cursor_q;
  assign player       = player_q;
  assign counter      = counter_q;
  assign add          = add_q;
  assign place_valid  = pv_q;
  assign place_row    = row_q;
  assign place_col    = col_q;
  assign place_player = pp_q;
  assign rejected     = rej_q;
endmodule

// File: tb/tb_drop_controller.sv
// tb_drop_controller: directed checks of cursor, drop, reject and reset behaviour with a column counter model
module tb_drop_controller;
  logic       clk = 1'b0, reset = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0, game_over = 1'b0;
  logic [2:0] h [4];
  logic [1:0] cursor, counter, place_col;
  logic [2:0] place_row;
  logic       player, add, place_valid, place_player, rejected;
  int         n_cmp = 0, n_err = 0, pulses;
  drop_controller #(.ROWS(4)) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
    .game_over(game_over), .height_0(h[0]), .height_1(h[1]), .height_2(h[2]), .height_3(h[3]),
    .cursor(cursor), .player(player), .counter(counter), .add(add), .place_valid(place_valid),
    .place_row(place_row), .place_col(place_col), .place_player(place_player), .rejected(rejected)
  );
  always #5 clk = ~clk;
  // column counter stage samples add on the falling edge
  always @(negedge clk) if (add) h[counter] <= h[counter] + 3'd1;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // pulse buttons {drop,right,left} for one edge, then release for one edge
  task automatic press(input logic [2:0] b);
    {btn_drop, btn_right, btn_left} = b;
    tick();
    {btn_drop, btn_right, btn_left} = 3'b000;
    tick();
  endtask
  initial begin
    for (int i = 0; i < 4; i++) h[i] = 3'd0;
    btn_right = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    chk("rst_cursor", 8'(cursor), 8'd0);
    chk("rst_player", 8'(player), 8'd0);
    chk("rst_add", 8'(add), 8'd0);
    chk("rst_pv", 8'(place_valid), 8'd0);
    chk("rst_rej", 8'(rejected), 8'd0);
    repeat (2) tick();
    chk("held_right", 8'(cursor), 8'd0);
    btn_right = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      press(3'b010);
      chk("right_wrap", 8'(cursor), 8'((i + 1) % 4));
    end
    press(3'b001);
    chk("left_wrap", 8'(cursor), 8'd3);
    press(3'b011);
    chk("left_right", 8'(cursor), 8'd3);
    press(3'b010);
    press(3'b010);
    press(3'b010);
    chk("to_col2", 8'(cursor), 8'd2);
    btn_drop = 1'b1;
    tick();
    chk("drop_add", 8'(add), 8'd1);
    chk("drop_counter", 8'(counter), 8'd2);
    chk("drop_pv", 8'(place_valid), 8'd1);
    chk("drop_row", 8'(place_row), 8'd0);
    chk("drop_col", 8'(place_col), 8'd2);
    chk("drop_pp", 8'(place_player), 8'd0);
    btn_drop = 1'b0;
    tick();
    chk("settle_add", 8'(add), 8'd0);
    chk("settle_pv", 8'(place_valid), 8'd0);
    chk("toggle_player", 8'(player), 8'd1);
    chk("height2", 8'(h[2]), 8'd1);
    chk("hold_counter", 8'(counter), 8'd2);
    chk("hold_col", 8'(place_col), 8'd2);
    tick();
    h[1] = 3'd4;
    press(3'b001);
    chk("to_col1", 8'(cursor), 8'd1);
    btn_drop = 1'b1;
    tick();
    chk("full_rej", 8'(rejected), 8'd1);
    chk("full_add", 8'(add), 8'd0);
    chk("full_pv", 8'(place_valid), 8'd0);
    btn_drop = 1'b0;
    tick();
    chk("rej_pulse", 8'(rejected), 8'd0);
    chk("rej_player", 8'(player), 8'd1);
    chk("rej_cursor", 8'(cursor), 8'd1);
    h[1] = 3'd7;
    press(3'b100);
    chk("over_full", 8'(add), 8'd0);
    chk("over_full_h", 8'(h[1]), 8'd7);
    game_over = 1'b1;
    press(3'b001);
    chk("go_move", 8'(cursor), 8'd0);
    btn_drop = 1'b1;
    tick();
    chk("go_rej", 8'(rejected), 8'd1);
    chk("go_add", 8'(add), 8'd0);
    btn_drop = 1'b0;
    game_over = 1'b0;
    tick();
    chk("go_h0", 8'(h[0]), 8'd0);
    pulses = 0;
    btn_drop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (add) begin
        pulses++;
        chk("held_pp", 8'(place_player), 8'd1);
      end
    end
    chk("held_pulses", 8'(pulses), 8'd1);
    btn_drop = 1'b0;
    tick();
    chk("held_h0", 8'(h[0]), 8'd1);
    chk("held_player", 8'(player), 8'd0);
    {btn_drop, btn_right} = 2'b11;
    tick();
    chk("dr_add", 8'(add), 8'd1);
    chk("dr_col", 8'(place_col), 8'd0);
    chk("dr_row", 8'(place_row), 8'd1);
    chk("dr_cursor", 8'(cursor), 8'd0);
    {btn_drop, btn_right} = 2'b00;
    tick();
    btn_drop = 1'b1;
    tick();
    chk("settle_ign_add", 8'(add), 8'd0);
    tick();
    chk("settle_ign_add2", 8'(add), 8'd0);
    chk("settle_ign_h0", 8'(h[0]), 8'd2);
    btn_drop = 1'b0;
    tick();
    btn_drop = 1'b1;
    tick();
    chk("pre_rst_add", 8'(add), 8'd1);
    btn_drop = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async_add", 8'(add), 8'd0);
    chk("async_player", 8'(player), 8'd0);
    chk("async_pv", 8'(place_valid), 8'd0);
    tick();
    chk("async_h0", 8'(h[0]), 8'd2);
    reset = 1'b1;
    tick();
    btn_drop = 1'b1;
    tick();
    chk("post_add", 8'(add), 8'd1);
    chk("post_pp", 8'(place_player), 8'd0);
    chk("post_row", 8'(place_row), 8'd2);
    chk("post_col", 8'(place_col), 8'd0);
    btn_drop = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
